skeeball_game_ctrl: RTL

- Game sequencer for the skeeball machine: owns the 2-bit game state (00 menu, 01 playing, 10 finish, 11 last score).
- Generates all state advances internally from the player button, ball sensors and hold timers; no external trigger input.
- Accumulates score per ball, counts balls remaining and holds the last completed score for the score display.
- Outputs feed the existing one-hot state decoder and the 7-segment display drivers.

---
 rtl/skeeball_pkg.sv | 29 ++
 rtl/skeeball_hole_encoder.sv | 29 ++
 rtl/skeeball_game_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/skeeball_pkg.sv
// Shared definitions for the skeeball game sequencer: state encodings,
// per-hole point values and default build parameters.
package skeeball_pkg;

    // Game state encoding, matches the external one-hot state decoder.
    typedef enum logic [1:0] {
        ST_MENU   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_FINISH = 2'b10,
        ST_SCORE  = 2'b11
    } state_e;

    // Width of a single ball's point value (max 100).
    localparam int PTS_W = 7;

    // Point value of each hole, hole[0]..hole[5].
    localparam logic [PTS_W-1:0] PTS_HOLE0 = 7'd10;
    localparam logic [PTS_W-1:0] PTS_HOLE1 = 7'd20;
    localparam logic [PTS_W-1:0] PTS_HOLE2 = 7'd30;
    localparam logic [PTS_W-1:0] PTS_HOLE3 = 7'd40;
    localparam logic [PTS_W-1:0] PTS_HOLE4 = 7'd50;
    localparam logic [PTS_W-1:0] PTS_HOLE5 = 7'd100;

    // Default build parameters.
    localparam int DEF_NUM_BALLS   = 9;
    localparam int DEF_HOLD_CYCLES = 50000000;
    localparam int DEF_SCORE_W     = 10;

endpackage

// File: rtl/skeeball_hole_encoder.sv
// Priority encoder for the six ball-in-hole sensors. When several sensors
// fire in the same cycle the highest-value hole wins.
module skeeball_hole_encoder
    import skeeball_pkg::*;
(
    input  logic [5:0]       hole,
    output logic [PTS_W-1:0] points,
    output logic             valid
);

    // Highest-value set bit selects the point value; no bit set means no hit.
    always_comb begin
        points = 7'd0;
        valid  = 1'b1;
        casez (hole)
            6'b1?????: points = PTS_HOLE5;
            6'b01????: points = PTS_HOLE4;
            6'b001???: points = PTS_HOLE3;
            6'b0001??: points = PTS_HOLE2;
            6'b00001?: points = PTS_HOLE1;
            6'b000001: points = PTS_HOLE0;
            default: begin
                points = 7'd0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/skeeball_game_ctrl.sv
// Skeeball game sequencer: menu -> playing -> finish -> last score -> menu.
// Accumulates score per ball, counts balls remaining and latches the last
// completed score. Optional high-score tracking is enabled by defining
// SKEEBALL_HIGH_SCORE_EN, which adds the high_score and new_high outputs.
module skeeball_game_ctrl
    import skeeball_pkg::*;
#(
    parameter int NUM_BALLS   = DEF_NUM_BALLS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic [5:0]         hole,
    input  logic               gutter,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] last_score,
    output logic [3:0]         balls_left,
    output logic               game_over
`ifdef SKEEBALL_HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high
`endif
);

    localparam int                 TIMER_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]         BALLS_INIT = 4'(NUM_BALLS);

    // Unsigned add that pins at all-ones if the score width is undersized.
    function automatic logic [SCORE_W-1:0] add_sat(input logic [SCORE_W-1:0] a,
                                                   input logic [PTS_W-1:0]   b);
        logic [SCORE_W:0] full;
        full = {1'b0, a} + (SCORE_W + 1)'(b);
        if (full[SCORE_W]) begin
            return {SCORE_W{1'b1}};
        end else begin
            return full[SCORE_W-1:0];
        end
    endfunction

    state_e             state_r, state_nxt_s;
    logic               btn_q_r;
    logic [TIMER_W-1:0] timer_r, timer_nxt_s;
    logic [SCORE_W-1:0] score_r, score_nxt_s;
    logic [SCORE_W-1:0] last_score_r, last_score_nxt_s;
    logic [3:0]         balls_r, balls_nxt_s;
    logic               game_over_r, game_over_nxt_s;

    logic               press_s;
    logic [PTS_W-1:0]   hole_pts_s;
    logic               hole_hit_s;
    logic               ball_accept_s;
    logic               last_ball_s;
    logic               timer_done_s;
    logic [SCORE_W-1:0] sum_s;

`ifdef SKEEBALL_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_r, high_score_nxt_s;
    logic               new_high_r, new_high_nxt_s;
`endif

    skeeball_hole_encoder u_hole_enc (
        .hole   (hole),
        .points (hole_pts_s),
        .valid  (hole_hit_s)
    );

    // A gutter return alone scores 0; a hole hit in the same cycle takes precedence.
    assign press_s       = start_btn & ~btn_q_r;
    assign ball_accept_s = (state_r == ST_PLAY) && (gutter || hole_hit_s) && (balls_r != 4'd0);
    assign last_ball_s   = (balls_r == 4'd1);
    assign timer_done_s  = (timer_r == TIMER_LAST);
    assign sum_s         = add_sat(score_r, hole_hit_s ? hole_pts_s : 7'd0);

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_MENU;
            btn_q_r      <= 1'b0;
            timer_r      <= '0;
            score_r      <= '0;
            last_score_r <= '0;
            balls_r      <= BALLS_INIT;
            game_over_r  <= 1'b0;
`ifdef SKEEBALL_HIGH_SCORE_EN
            high_score_r <= '0;
            new_high_r   <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            btn_q_r      <= start_btn;
            timer_r      <= timer_nxt_s;
            score_r      <= score_nxt_s;
            last_score_r <= last_score_nxt_s;
            balls_r      <= balls_nxt_s;
            game_over_r  <= game_over_nxt_s;
`ifdef SKEEBALL_HIGH_SCORE_EN
            high_score_r <= high_score_nxt_s;
            new_high_r   <= new_high_nxt_s;
`endif
        end
    end

    // Next-state selection from button edge, last ball and hold timer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_MENU: begin
                if (press_s) state_nxt_s = ST_PLAY;
                else         state_nxt_s = ST_MENU;
            end
            ST_PLAY: begin
                if (ball_accept_s && last_ball_s) state_nxt_s = ST_FINISH;
                else                              state_nxt_s = ST_PLAY;
            end
            ST_FINISH: begin
                if (press_s || timer_done_s) state_nxt_s = ST_SCORE;
                else                         state_nxt_s = ST_FINISH;
            end
            ST_SCORE: begin
                if (press_s || timer_done_s) state_nxt_s = ST_MENU;
                else                         state_nxt_s = ST_SCORE;
            end
            default: state_nxt_s = ST_MENU;
        endcase
    end

    // Next values for timer, score, ball count and game-over pulse.
    always_comb begin
        score_nxt_s      = score_r;
        last_score_nxt_s = last_score_r;
        balls_nxt_s      = balls_r;
        game_over_nxt_s  = 1'b0;
        timer_nxt_s      = '0;

        // The timer restarts on every state change and only runs in the hold states.
        if (state_nxt_s != state_r) begin
            timer_nxt_s = '0;
        end else if ((state_r == ST_FINISH) || (state_r == ST_SCORE)) begin
            timer_nxt_s = timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            timer_nxt_s = '0;
        end

        case (state_r)
            ST_MENU: begin
                if (press_s) begin
                    score_nxt_s = '0;
                    balls_nxt_s = BALLS_INIT;
                end else begin
                    score_nxt_s = score_r;
                end
            end
            ST_PLAY: begin
                if (ball_accept_s) begin
                    score_nxt_s = sum_s;
                    balls_nxt_s = balls_r - 4'd1;
                    if (last_ball_s) begin
                        game_over_nxt_s  = 1'b1;
                        last_score_nxt_s = sum_s;
                    end else begin
                        game_over_nxt_s  = 1'b0;
                    end
                end else begin
                    score_nxt_s = score_r;
                end
            end
            ST_FINISH: score_nxt_s = score_r;
            ST_SCORE:  score_nxt_s = score_r;
            default:   score_nxt_s = score_r;
        endcase
    end

`ifdef SKEEBALL_HIGH_SCORE_EN
    // High-score capture at game end; new_high lasts until the menu is re-entered.
    always_comb begin
        high_score_nxt_s = high_score_r;
        new_high_nxt_s   = new_high_r;
        if (ball_accept_s && last_ball_s && (sum_s > high_score_r)) begin
            high_score_nxt_s = sum_s;
            new_high_nxt_s   = 1'b1;
        end else if ((state_nxt_s == ST_MENU) && (state_r != ST_MENU)) begin
            new_high_nxt_s   = 1'b0;
        end else begin
            new_high_nxt_s   = new_high_r;
        end
    end

    assign high_score = high_score_r;
    assign new_high   = new_high_r;
`endif

    assign state      = state_r;
    assign score      = score_r;
    assign last_score = last_score_r;
    assign balls_left = balls_r;
    assign game_over  = game_over_r;

endmodule
